// File: rtl/partition_err_monitor.sv
// Exhaustive response checker for one combinational partition: sweeps every
// input pattern and accumulates error-rate, Hamming, absolute-error metrics.
module partition_err_monitor #(
    parameter int PI_W = 5,
    parameter int PO_W = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic [PI_W-1:0]                    pi,
    input  logic [PO_W-1:0]                    approx_po,
    input  logic [PO_W-1:0]                    exact_po,
    output logic                               busy,
    output logic                               done,
    output logic [PI_W:0]                      err_count,
    output logic [PI_W+$clog2(PO_W+1)-1:0]     hd_sum,
    output logic [PI_W+PO_W-1:0]               abs_err_sum,
    output logic [PO_W-1:0]                    max_abs_err
);

    localparam int ERR_W    = PI_W + 1;
    localparam int HD_INC_W = $clog2(PO_W + 1);
    localparam int HD_W     = PI_W + HD_INC_W;
    localparam int ABS_W    = PI_W + PO_W;
    localparam logic [PI_W-1:0] PI_LAST = {PI_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [HD_INC_W-1:0] popcount(input logic [PO_W-1:0] v);
        logic [HD_INC_W-1:0] cnt;
        cnt = {HD_INC_W{1'b0}};
        for (int i = 0; i < PO_W; i++) begin
            cnt = cnt + HD_INC_W'(v[i]);
        end
        return cnt;
    endfunction

    state_t              r_state;
    logic [PI_W-1:0]     r_pi;
    logic [ERR_W-1:0]    r_err;
    logic [HD_W-1:0]     r_hd;
    logic [ABS_W-1:0]    r_abs;
    logic [PO_W-1:0]     r_max;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [PI_W-1:0]     w_pi_nxt;
    logic [ERR_W-1:0]    w_err_nxt;
    logic [HD_W-1:0]     w_hd_nxt;
    logic [ABS_W-1:0]    w_abs_nxt;
    logic [PO_W-1:0]     w_max_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [PO_W-1:0]     w_diff;
    logic [PO_W-1:0]     w_xor;
    logic                w_is_err;

    // Unsigned absolute difference by compare-and-subtract, plus bitwise mismatch.
    always_comb begin
        w_diff = {PO_W{1'b0}};
        if (approx_po >= exact_po) begin
            w_diff = approx_po - exact_po;
        end else begin
            w_diff = exact_po - approx_po;
        end
        w_xor    = approx_po ^ exact_po;
        w_is_err = (w_diff != {PO_W{1'b0}});
    end

    // Sweep sequencing and accumulator next-state; outputs are decoded from next state.
    always_comb begin
        w_state_nxt = r_state;
        w_pi_nxt    = r_pi;
        w_err_nxt   = r_err;
        w_hd_nxt    = r_hd;
        w_abs_nxt   = r_abs;
        w_max_nxt   = r_max;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                    w_pi_nxt    = {PI_W{1'b0}};
                    w_err_nxt   = {ERR_W{1'b0}};
                    w_hd_nxt    = {HD_W{1'b0}};
                    w_abs_nxt   = {ABS_W{1'b0}};
                    w_max_nxt   = {PO_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_err_nxt = r_err + ERR_W'(w_is_err);
                w_hd_nxt  = r_hd + HD_W'(popcount(w_xor));
                w_abs_nxt = r_abs + ABS_W'(w_diff);
                if (w_diff > r_max) begin
                    w_max_nxt = w_diff;
                end else begin
                    w_max_nxt = r_max;
                end
                // Last pattern is found by compare so pi never wraps back to zero.
                if (r_pi == PI_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_pi_nxt    = r_pi + PI_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SAMPLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State, pattern, metric and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pi    <= {PI_W{1'b0}};
            r_err   <= {ERR_W{1'b0}};
            r_hd    <= {HD_W{1'b0}};
            r_abs   <= {ABS_W{1'b0}};
            r_max   <= {PO_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pi    <= w_pi_nxt;
            r_err   <= w_err_nxt;
            r_hd    <= w_hd_nxt;
            r_abs   <= w_abs_nxt;
            r_max   <= w_max_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign pi          = r_pi;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_count   = r_err;
    assign hd_sum      = r_hd;
    assign abs_err_sum = r_abs;
    assign max_abs_err = r_max;

endmodule

// File: tb/tb_partition_err_monitor.sv
// Directed bench for partition_err_monitor: per-step scoreboard of every metric
// plus hand-computed sweep totals, restart, ignored start and async reset cases.
module tb_partition_err_monitor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] pi;
    logic [4:0] approx_po;
    logic [4:0] exact_po;
    logic       busy;
    logic       done;
    logic [5:0] err_count;
    logic [7:0] hd_sum;
    logic [9:0] abs_err_sum;
    logic [4:0] max_abs_err;

    int n_checks;
    int n_pass;
    int tb_mode;
    bit tb_glitch;

    partition_err_monitor #(.PI_W(5), .PO_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pi          (pi),
        .approx_po   (approx_po),
        .exact_po    (exact_po),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .hd_sum      (hd_sum),
        .abs_err_sum (abs_err_sum),
        .max_abs_err (max_abs_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] exact_f(input int mode, input logic [4:0] p);
        return p;
    endfunction

    function automatic logic [4:0] approx_f(input int mode, input logic [4:0] p);
        logic [4:0] r;
        case (mode)
            1:       r = p | 5'd1;
            2:       r = ~p;
            3:       r = p ^ 5'd3;
            default: r = p;
        endcase
        return r;
    endfunction

    // Partition stand-ins; mode 3 drives garbage on approx_po while in DRIVE.
    always_comb begin
        exact_po  = exact_f(tb_mode, pi);
        approx_po = approx_f(tb_mode, pi);
        if (tb_glitch) begin
            approx_po = ~pi;
        end else begin
            approx_po = approx_f(tb_mode, pi);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_pi"},   32'(pi), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"},  32'(err_count), 32'd0);
        check_val({tag, "_hd"},   32'(hd_sum), 32'd0);
        check_val({tag, "_abs"},  32'(abs_err_sum), 32'd0);
        check_val({tag, "_max"},  32'(max_abs_err), 32'd0);
    endtask

    // One sweep with scoreboard at every step; optional ignored start and async reset.
    task automatic run_sweep(input int mode, input int mid_start, input int rst_at,
                             input int e_err, input int e_hd, input int e_abs, input int e_max);
        int m_err, m_hd, m_abs, m_max;
        int ap, ex, d;
        int exp_pi;
        tb_mode = mode;
        m_err = 0; m_hd = 0; m_abs = 0; m_max = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 64; c++) begin
            if (c >= 2 && (c % 2) == 0) begin
                ap = int'(approx_f(mode, 5'(c / 2 - 1)));
                ex = int'(exact_f(mode, 5'(c / 2 - 1)));
                d  = (ap > ex) ? ap - ex : ex - ap;
                m_err += (d != 0) ? 1 : 0;
                m_hd  += $countones(5'(ap ^ ex));
                m_abs += d;
                if (d > m_max) m_max = d;
            end
            exp_pi = (c == 64) ? 31 : c / 2;
            check_val("step_pi",   32'(pi), 32'(exp_pi));
            check_val("step_busy", 32'(busy), (c < 64) ? 32'd1 : 32'd0);
            check_val("step_done", 32'(done), (c == 64) ? 32'd1 : 32'd0);
            check_val("step_err",  32'(err_count), 32'(m_err));
            check_val("step_hd",   32'(hd_sum), 32'(m_hd));
            check_val("step_abs",  32'(abs_err_sum), 32'(m_abs));
            check_val("step_max",  32'(max_abs_err), 32'(m_max));
            if (c < 64) begin
                tb_glitch = (mode == 3) && ((c % 2) == 0);
                start = (c == mid_start);
                if (c == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1 check_zero_outputs("async_rst");
                    tb_glitch = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    check_zero_outputs("rst_hold");
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        tb_glitch = 1'b0;
        check_val("final_err", 32'(err_count), 32'(e_err));
        check_val("final_hd",  32'(hd_sum), 32'(e_hd));
        check_val("final_abs", 32'(abs_err_sum), 32'(e_abs));
        check_val("final_max", 32'(max_abs_err), 32'(e_max));
        @(negedge clk);
        check_val("done_hold", 32'(done), 32'd1);
        check_val("done_err_hold", 32'(err_count), 32'(e_err));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        tb_mode   = 0;
        tb_glitch = 1'b0;
        start     = 1'b0;
        rst_n     = 1'b0;
        #3 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("idle");

        run_sweep(0, -1, -1,  0,   0,   0,  0);
        run_sweep(1, -1, -1, 16,  16,  16,  1);
        run_sweep(2, -1, -1, 32, 160, 512, 31);
        run_sweep(3, -1, -1, 32,  64,  64,  3);
        run_sweep(1, 10, -1, 16,  16,  16,  1);
        run_sweep(1, -1, -1, 16,  16,  16,  1);
        run_sweep(2, -1, 20, 32, 160, 512, 31);
        run_sweep(2, -1, -1, 32, 160, 512, 31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
